// File: rtl/spi_resp_pkg.sv
// -----------------------------------------------------------------------------
// spi_resp_pkg
// Shared definitions for the SPI flash responder: supported opcodes of the
// IS25WP032D command subset and the transaction FSM state encoding.
// -----------------------------------------------------------------------------
package spi_resp_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DOUT,
        DIN,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_resp_ram.sv
// -----------------------------------------------------------------------------
// spi_resp_ram
// Byte-wide single-clock RAM backing the emulated flash array.
// One write port and one registered (1-cycle latency) read port. A read of the
// address being written in the same cycle returns the new data.
// Ports:
//   clk    in   system clock
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module spi_resp_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Write-first on an address collision.
        if (we && (waddr == raddr)) begin
            rdata_reg <= wdata;
        end else begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
// SPI mode-0 responder emulating the boot flash (READ/PP/RDID/RDSR/WREN/WRDI)
// on top of on-chip RAM. All SPI pins are oversampled in the clk domain.
// Ports:
//   clk      in   system clock (SCLK <= clk/8)
//   reset    in   asynchronous active-low reset
//   sclk     in   SPI clock (async)
//   scs      in   SPI chip select, active-low (async)
//   mosi     in   SPI data master->responder (async)
//   miso     out  SPI data responder->master
//   miso_oe  out  MISO output enable (high while synced SCS is low)
//   ld_en    in   backdoor RAM write strobe
//   ld_addr  in   backdoor write address
//   ld_data  in   backdoor write data
//   wel      out  write-enable latch
//   cmd_err  out  one-cycle pulse on an unsupported opcode
// -----------------------------------------------------------------------------
import spi_resp_pkg::*;

module spi_flash_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [23:0] JEDEC_ID    = 24'h9D7016,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              scs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              wel,
    output logic              cmd_err
);

    // Synchronizers: bit 0 = sclk, bit 1 = scs, bit 2 = mosi.
    // SCS resets to its inactive (high) level so miso_oe is low out of reset.
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] pins_async;
    logic [2:0] pins_s;

    assign pins_async = {mosi, scs, sclk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
            end else begin
                chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins_async[gi]};
            end
        end
        assign pins_s[gi] = chain_reg[SYNC_STAGES-1];
    end

    logic sclk_s, scs_s, mosi_s;
    logic sclk_d_reg, scs_d_reg;
    logic sclk_rise, sclk_fall, scs_rise;

    assign sclk_s = pins_s[0];
    assign scs_s  = pins_s[1];
    assign mosi_s = pins_s[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_d_reg <= 1'b0;
            scs_d_reg  <= 1'b1;
        end else begin
            sclk_d_reg <= sclk_s;
            scs_d_reg  <= scs_s;
        end
    end

    // SCLK edges only count while selected.
    assign sclk_rise = !scs_s && sclk_s && !sclk_d_reg;
    assign sclk_fall = !scs_s && !sclk_s && sclk_d_reg;
    assign scs_rise  = scs_s && !scs_d_reg;

    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg;
    logic [1:0]        byte_cnt_reg;
    logic [7:0]        shift_reg;
    logic [7:0]        cmd_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        out_reg;
    logic              miso_reg;
    logic              wel_reg;
    logic              cmd_err_reg, cmd_err_next;
    logic [1:0]        load_pipe_reg;
    logic [1:0]        id_idx_reg;
    logic              wr_pend_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;
    logic [7:0]        ram_rdata;
    logic [7:0]        byte_in;
    logic              byte_done;
    logic              load_start;
    logic              load_now;
    logic [7:0]        id_byte;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    assign byte_in   = {shift_reg[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);

    // A response byte is needed right after the command (RDID/RDSR), after
    // the last address byte of READ, and at every byte boundary in DOUT.
    // The two-stage pipe covers the RAM address update plus read latency.
    assign load_start = byte_done && (
        (state_reg == CMD  && (byte_in == OP_RDID || byte_in == OP_RDSR)) ||
        (state_reg == ADDR && byte_cnt_reg == 2'd2 && cmd_reg == OP_READ) ||
        (state_reg == DOUT));
    assign load_now = load_pipe_reg[1];

    always_comb begin
        id_byte = 8'hFF;
        case (id_idx_reg)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cmd_err_next = 1'b0;
        if (scs_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (byte_in)
                            OP_READ, OP_PP:     state_next = ADDR;
                            OP_RDID, OP_RDSR:   state_next = DOUT;
                            OP_WREN, OP_WRDI:   state_next = IGNORE;
                            default: begin
                                state_next   = IGNORE;
                                cmd_err_next = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_done && byte_cnt_reg == 2'd2) begin
                        state_next = (cmd_reg == OP_READ) ? DOUT : DIN;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_reg   <= '0;
            byte_cnt_reg  <= '0;
            shift_reg     <= '0;
            cmd_reg       <= '0;
            addr_reg      <= '0;
            out_reg       <= '0;
            miso_reg      <= 1'b0;
            wel_reg       <= 1'b0;
            cmd_err_reg   <= 1'b0;
            load_pipe_reg <= '0;
            id_idx_reg    <= '0;
            wr_pend_reg   <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            cmd_err_reg   <= cmd_err_next;
            wr_pend_reg   <= 1'b0;
            load_pipe_reg <= {load_pipe_reg[0], load_start};

            if (scs_s) begin
                // Deselect discards any partial byte and pending response.
                bit_cnt_reg   <= '0;
                byte_cnt_reg  <= '0;
                shift_reg     <= '0;
                miso_reg      <= 1'b0;
                load_pipe_reg <= '0;
                id_idx_reg    <= '0;
            end else begin
                if (sclk_rise) begin
                    shift_reg   <= byte_in;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                if (byte_done) begin
                    case (state_reg)
                        CMD: begin
                            cmd_reg      <= byte_in;
                            byte_cnt_reg <= '0;
                        end
                        ADDR: begin
                            // 24-bit address shifted in; only the low bits survive.
                            addr_reg     <= ADDR_W'({addr_reg, byte_in});
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                        DIN: begin
                            if (wel_reg) begin
                                wr_pend_reg <= 1'b1;
                                wr_addr_reg <= addr_reg;
                                wr_data_reg <= byte_in;
                            end
                            // Page program wraps within the 256-byte page.
                            addr_reg[7:0] <= addr_reg[7:0] + 8'd1;
                        end
                        default: ;
                    endcase
                end
                if (load_now) begin
                    case (cmd_reg)
                        OP_READ: begin
                            out_reg  <= ram_rdata;
                            addr_reg <= addr_reg + ADDR_ONE;
                        end
                        OP_RDID: begin
                            out_reg <= id_byte;
                            if (id_idx_reg != 2'd3) begin
                                id_idx_reg <= id_idx_reg + 2'd1;
                            end
                        end
                        default: out_reg <= {6'b0, wel_reg, 1'b0};
                    endcase
                end
                if (sclk_fall) begin
                    if (state_reg == DOUT) begin
                        miso_reg <= out_reg[7];
                        out_reg  <= {out_reg[6:0], 1'b0};
                    end else begin
                        miso_reg <= 1'b0;
                    end
                end
            end

            // Write-enable latch commits on deselect. A PP only consumes the
            // latch if it ended on a byte boundary in the data phase, so an
            // aborted partial byte leaves wel intact.
            if (scs_rise) begin
                if (state_reg == IGNORE && cmd_reg == OP_WREN) begin
                    wel_reg <= 1'b1;
                end else if (state_reg == IGNORE && cmd_reg == OP_WRDI) begin
                    wel_reg <= 1'b0;
                end else if (state_reg == DIN && bit_cnt_reg == 3'd0) begin
                    wel_reg <= 1'b0;
                end
            end
        end
    end

    // Backdoor preload wins over a same-cycle page-program write.
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    assign ram_we    = ld_en || wr_pend_reg;
    assign ram_waddr = ld_en ? ld_addr : wr_addr_reg;
    assign ram_wdata = ld_en ? ld_data : wr_data_reg;

    spi_resp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr_reg),
        .rdata (ram_rdata)
    );

    assign miso    = miso_reg;
    assign miso_oe = !scs_s;
    assign wel     = wel_reg;
    assign cmd_err = cmd_err_reg;

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_responder
// Directed bench: drives SPI mode-0 transactions at SCLK = clk/8 and samples
// MISO just before each SCLK rise. Expected bytes are hand-computed.
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sclk = 1'b0;
    logic              scs = 1'b1;
    logic              mosi = 1'b0;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]        ld_data = '0;
    logic              miso, miso_oe, wel, cmd_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    logic [7:0] txb [8];
    logic [7:0] rxb [8];
    logic [7:0] dummy;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_W      (ADDR_W),
        .JEDEC_ID    (24'h9D7016),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sclk    (sclk),
        .scs     (scs),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .wel     (wel),
        .cmd_err (cmd_err)
    );

    always @(posedge clk) begin
        if (reset && cmd_err) err_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift n bits of tx (MSB first); returns the MISO bits seen at each rise.
    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            tick(4);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_start();
        scs = 1'b0;
        tick(4);
    endtask

    task automatic spi_stop();
        tick(4);
        scs = 1'b1;
        tick(8);
    endtask

    task automatic txn(input string name, input int n);
        spi_start();
        for (int i = 0; i < n; i++) xfer_bits(txb[i], 8, rxb[i]);
        spi_stop();
        $display("txn %-8s n=%0d tx=%h %h %h %h %h %h rx=%h %h %h %h %h %h", name, n,
                 txb[0], txb[1], txb[2], txb[3], txb[4], txb[5],
                 rxb[0], rxb[1], rxb[2], rxb[3], rxb[4], rxb[5]);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        tick(1);
        ld_en   = 1'b0;
        $display("txn LOAD     [%h]=%h", a, d);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_miso", miso, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_wel", wel, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        reset = 1'b1;
        tick(4);

        // RDID with miso_oe observed inside and after the transaction
        txb = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        spi_start();
        check("oe_sel", miso_oe, 1'b1);
        for (int i = 0; i < 5; i++) xfer_bits(txb[i], 8, rxb[i]);
        spi_stop();
        $display("txn RDID     rx=%h %h %h %h", rxb[1], rxb[2], rxb[3], rxb[4]);
        check("rdid_b0", rxb[1], 8'h9D);
        check("rdid_b1", rxb[2], 8'h70);
        check("rdid_b2", rxb[3], 8'h16);
        check("rdid_b3", rxb[4], 8'hFF);
        check("oe_desel", miso_oe, 1'b0);

        // Preload and READ, including the top-of-array wrap
        load(12'h010, 8'hA5);
        load(12'h011, 8'h3C);
        load(12'hFFF, 8'h77);
        load(12'h000, 8'h5A);
        load(12'h020, 8'hC3);
        load(12'h040, 8'h99);
        txb = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("READ", 6);
        check("read_010", rxb[4], 8'hA5);
        check("read_011", rxb[5], 8'h3C);
        txb = '{8'h03, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("READ", 6);
        check("read_fff", rxb[4], 8'h77);
        check("read_wrap", rxb[5], 8'h5A);

        // PP without WREN is dropped
        txb = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h55, 8'h00, 8'h00, 8'h00};
        txn("PP", 5);
        txb = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("READ", 5);
        check("pp_nowel", rxb[4], 8'hC3);
        txb = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("RDSR", 2);
        check("rdsr_idle", rxb[1], 8'h00);
        check("no_cmd_err", err_pulses, 0);

        // WREN, status, page program with page wrap
        txb = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("WREN", 1);
        check("wel_set", wel, 1'b1);
        txb = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("RDSR", 3);
        check("rdsr_wel", rxb[1], 8'h02);
        check("rdsr_rep", rxb[2], 8'h02);
        txb = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h00, 8'h00};
        txn("PP", 6);
        txb = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("RDSR", 2);
        check("rdsr_pp_clr", rxb[1], 8'h00);
        txb = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("READ", 5);
        check("pp_0ff", rxb[4], 8'h11);
        txb = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("READ", 5);
        check("pp_pagewrap", rxb[4], 8'h22);

        // WREN then PP aborted after 4 data bits
        txb = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("WREN", 1);
        spi_start();
        xfer_bits(8'h02, 8, dummy);
        xfer_bits(8'h00, 8, dummy);
        xfer_bits(8'h00, 8, dummy);
        xfer_bits(8'h40, 8, dummy);
        xfer_bits(8'hE0, 4, dummy);
        spi_stop();
        $display("txn PP-PART  addr=040 bits=4");
        check("partial_wel", wel, 1'b1);
        txb = '{8'h03, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("READ", 5);
        check("partial_mem", rxb[4], 8'h99);

        // Unsupported opcode
        txb = '{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("BAD", 2);
        check("bad_miso", rxb[1], 8'h00);
        check("bad_cmd_err", err_pulses, 1);

        // WRDI clears the latch
        txb = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("WRDI", 1);
        check("wel_clr", wel, 1'b0);

        // Reset asserted 12 bits into a READ
        txb = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("WREN", 1);
        check("wel_pre_rst", wel, 1'b1);
        spi_start();
        xfer_bits(8'h03, 8, dummy);
        xfer_bits(8'h00, 4, dummy);
        reset = 1'b0;
        #1;
        check("mid_rst_miso", miso, 1'b0);
        check("mid_rst_oe", miso_oe, 1'b0);
        check("mid_rst_wel", wel, 1'b0);
        $display("txn RESET    mid-READ at bit 12");
        tick(2);
        scs = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(8);
        txb = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn("RDID", 2);
        check("rdid_after_rst", rxb[1], 8'h9D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
